mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset is synchronous and active-high.
REQ-002 SHALL have inputs: EX_valid 1, EX slot holds an instruction; EX_aluresult 32, address or ALU result; EX_writedata 32, store data; EX_writereg 5, destination register; EX_memread 1, load; EX_memwrite 1, store; EX_memtoreg 1; EX_branch 1; EX_zero 1.
REQ-003 SHALL have inputs: stall 1, hold slot; flush 1, squash slot.
REQ-004 SHALL have outputs: MEM_aluresult 32; MEM_memread 32, load data; MEM_writereg 5; MEM_memtoreg 1; MEM_pcsrc 1; MEM_valid 1, slot complete; mem_busy 1, upstream must hold EX inputs; MEM_misalign 1, error flag.
REQ-005 SHALL contain a 64 x 32-bit data memory, index = aluresult[7:2]; bits [31:8] ignored (address wraps every 256 bytes).

Function
REQ-006 SHALL keep one slot with FSM states EMPTY, ST, LD1, LD2, READY.
REQ-007 Capture permitted when state is EMPTY or READY and stall=0 and flush=0.
REQ-008 On a capture edge: EX_valid=0 -> EMPTY; load, aligned -> LD1; store, aligned -> ST; misaligned access (aluresult[1:0]!=0 with memread or memwrite) -> READY with MEM_misalign=1; neither load nor store -> READY.
REQ-009 EX_memread and EX_memwrite both 1: treated as load, store suppressed.
REQ-010 Slot captures aluresult, writedata, writereg, memtoreg, and pcsrc = EX_branch & EX_zero.
REQ-011 LD1 -> LD2 -> READY, one edge each; memory word latched into MEM_memread on the LD2->READY edge. Load latency: 3 edges from capture to MEM_valid.
REQ-012 ST -> READY after one edge; memory word written exactly once, on that edge, with slot writedata.
REQ-013 mem_busy = 1 in ST, LD1, LD2 (combinational from state); 0 otherwise.
REQ-014 MEM_valid = 1 only in READY.
REQ-015 When MEM_valid=0: MEM_writereg = 0, MEM_pcsrc = 0, MEM_memtoreg = 0, MEM_misalign = 0. Downstream writes to register 0 are discarded, so a bubble is harmless.
REQ-016 MEM_memread = 0 unless the READY slot holds a completed aligned load.
REQ-017 stall=1 in READY: slot and all outputs held; no memory access.
REQ-018 stall=1 in ST/LD1/LD2: ignored; the access continues.
REQ-019 flush=1 in any state: next state EMPTY.
REQ-020 flush in LD1/LD2: load abandoned.
REQ-021 flush in ST: store NOT committed.
REQ-022 flush and stall together: flush wins.
REQ-023 Misaligned access: SHALL NOT read or write memory; MEM_writereg forced 0 while flagged.
REQ-024 Back-to-back: a READY slot SHALL be replaced on the same edge that captures the next EX instruction (no bubble for non-memory instructions).

Reset
REQ-025 rst=1 at an edge: state EMPTY; all MEM_* outputs 0; mem_busy 0; all 64 memory words cleared to 0.
REQ-026 rst SHALL take priority over flush, stall and any access in progress; an in-flight store is not committed.

Verification
REQ-027 Reset, then EX ALU op (aluresult=0x2A, writereg=5, EX_valid=1) -> next edge MEM_valid=1, MEM_aluresult=0x2A, MEM_writereg=5, mem_busy=0.
REQ-028 Store 0xDEADBEEF at 0x10, then load from 0x10 (writereg=8) -> store: mem_busy=1 for 1 cycle; load: mem_busy=1 for 2 cycles; then MEM_memread=0xDEADBEEF, MEM_writereg=8, MEM_valid=1.
REQ-029 Load from 0x113 -> MEM_misalign=1, MEM_writereg=0, MEM_memread=0, mem_busy stays 0. Load from 0x110 returns the word stored at 0x10 (wrap).
REQ-030 Store 0x1234 at 0x20 with flush=1 during ST, then load 0x20 -> MEM_memread=0. Load with flush in LD1 -> EMPTY, MEM_valid=0.
REQ-031 READY slot with stall=1 held for 3 cycles while EX inputs change -> outputs unchanged. Branch=1, zero=1 gives MEM_pcsrc=1 only while MEM_valid=1.
REQ-032 rst asserted in LD2 -> next edge state EMPTY, all outputs 0. Subsequent load of any address returns 0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: single-slot memory pipeline stage backed by a 64 x 32-bit data memory.
// Loads complete three edges after capture, stores two; misaligned accesses are flagged and never touch memory.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_valid,
    input  logic [31:0] EX_aluresult,
    input  logic [31:0] EX_writedata,
    input  logic [4:0]  EX_writereg,
    input  logic        EX_memread,
    input  logic        EX_memwrite,
    input  logic        EX_memtoreg,
    input  logic        EX_branch,
    input  logic        EX_zero,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] MEM_aluresult,
    output logic [31:0] MEM_memread,
    output logic [4:0]  MEM_writereg,
    output logic        MEM_memtoreg,
    output logic        MEM_pcsrc,
    output logic        MEM_valid,
    output logic        mem_busy,
    output logic        MEM_misalign
);

    // state | meaning
    // EMPTY | no instruction held
    // ST    | aligned store pending; memory written on exit
    // LD1   | aligned load, first wait cycle
    // LD2   | aligned load; memory word captured on exit
    // READY | slot complete, outputs valid
    typedef enum logic [2:0] {EMPTY, ST, LD1, LD2, READY} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mem [64];
    logic [31:0] slot_alu;
    logic [31:0] slot_wdata;
    logic [31:0] slot_ldata;
    logic [4:0]  slot_reg;
    logic        slot_mtr;
    logic        slot_pcsrc;
    logic        slot_load;
    logic        slot_mis;
    logic [5:0]  slot_idx;
    logic        capture;
    logic        ex_access;
    logic        ex_mis;

    assign capture   = (state == EMPTY || state == READY) && !stall && !flush;
    assign ex_access = EX_memread | EX_memwrite;
    assign ex_mis    = ex_access && (EX_aluresult[1:0] != 2'b00);
    assign slot_idx  = slot_alu[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY, READY: begin
                    if (!stall) begin
                        if (!EX_valid) begin
                            state_next = EMPTY;
                        end else if (ex_mis || !ex_access) begin
                            state_next = READY;
                        end else if (EX_memread) begin
                            state_next = LD1;
                        end else begin
                            state_next = ST;
                        end
                    end
                end
                ST:      state_next = READY;
                LD1:     state_next = LD2;
                LD2:     state_next = READY;
                default: state_next = EMPTY;
            endcase
        end
    end

    // A load with memwrite also set is still a load; the store side is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_alu   <= '0;
            slot_wdata <= '0;
            slot_ldata <= '0;
            slot_reg   <= '0;
            slot_mtr   <= 1'b0;
            slot_pcsrc <= 1'b0;
            slot_load  <= 1'b0;
            slot_mis   <= 1'b0;
        end else if (capture) begin
            slot_alu   <= EX_aluresult;
            slot_wdata <= EX_writedata;
            slot_ldata <= '0;
            slot_reg   <= EX_writereg;
            slot_mtr   <= EX_memtoreg;
            slot_pcsrc <= EX_branch & EX_zero;
            slot_load  <= EX_memread && !ex_mis;
            slot_mis   <= ex_mis;
        end else if (state == LD2 && !flush) begin
            slot_ldata <= mem[slot_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST && !flush) begin
            mem[slot_idx] <= slot_wdata;
        end
    end

    assign MEM_valid     = (state == READY);
    assign mem_busy      = (state == ST) || (state == LD1) || (state == LD2);
    assign MEM_aluresult = slot_alu;
    assign MEM_memread   = (MEM_valid && slot_load) ? slot_ldata : '0;
    assign MEM_writereg  = (MEM_valid && !slot_mis) ? slot_reg : '0;
    assign MEM_memtoreg  = MEM_valid && slot_mtr;
    assign MEM_pcsrc     = MEM_valid && slot_pcsrc;
    assign MEM_misalign  = MEM_valid && slot_mis;

endmodule
